// File: rtl/inst_queue.sv
// Dual-wide instruction queue between fetch and the dual-issue decode stage.
// Fetch pushes 0-2 entries per cycle; decode sees the two oldest entries as
// slot 1 / slot 2 and retires 0, 1 or 2 of them per cycle.
//
// Handshake: fetch_valid1/fetch_valid2 are the push "valid" signals and
// fetch_stall_o is the inverse of "ready". A push happens on a rising edge
// only when fetch_valid1 is high and fetch_stall_o is low; fetch_valid2 only
// counts together with fetch_valid1. fetch_stall_o depends solely on the
// registered occupancy, so it never combinationally depends on fetch_valid*
// or on the same cycle's pop. On the decode side issue_en1/issue_en2 are the
// "valid" flags of slot 1 / slot 2 and issue_i/issue_dual_i request the pop;
// a request larger than the occupancy is trimmed, never an underflow.
module inst_queue #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4,
   parameter int PKT_W = 35
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             fetch_valid1,
   input  logic             fetch_valid2,
   input  logic [31:0]      fetch_inst1,
   input  logic [31:0]      fetch_inst2,
   input  logic [31:0]      fetch_addr1,
   input  logic [31:0]      fetch_addr2,
   input  logic [PKT_W-1:0] fetch_pkt1,
   input  logic [PKT_W-1:0] fetch_pkt2,
   output logic             fetch_stall_o,
   output logic [31:0]      inst_o1,
   output logic [31:0]      inst_o2,
   output logic [31:0]      inst_addr_o1,
   output logic [31:0]      inst_addr_o2,
   output logic [PKT_W-1:0] predict_pkt_o,
   output logic             issue_en1,
   output logic             issue_en2,
   input  logic             issue_i,
   input  logic             issue_dual_i,
   input  logic             next_in_delayslot_i,
   output logic             is_in_delayslot_o
);

   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_TWO   = (PTR_W+1)'(2);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   // Storage (not reset; validity comes from r_count)
   logic [31:0]      r_inst_mem [DEPTH];
   logic [31:0]      r_addr_mem [DEPTH];
   logic [PKT_W-1:0] r_pkt_mem  [DEPTH];

   // Control state
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_delayslot;

   logic [PTR_W:0]   w_free;
   logic [1:0]       w_push_n;
   logic [1:0]       w_req_n;
   logic [1:0]       w_pop_n;
   logic [PTR_W-1:0] w_wr_ptr1;
   logic [PTR_W-1:0] w_rd_ptr1;

   assign w_free        = DEPTH_CNT - r_count;
   assign fetch_stall_o = (w_free < CNT_TWO);
   assign w_wr_ptr1     = r_wr_ptr + PTR_ONE;
   assign w_rd_ptr1     = r_rd_ptr + PTR_ONE;

   // Push/pop amounts: pushes gated by the registered stall, pops trimmed to occupancy
   always_comb begin
      w_push_n = 2'd0;
      w_req_n  = 2'd0;
      w_pop_n  = 2'd0;
      if (!fetch_stall_o && fetch_valid1) begin
         w_push_n = fetch_valid2 ? 2'd2 : 2'd1;
      end
      if (issue_i) begin
         w_req_n = issue_dual_i ? 2'd2 : 2'd1;
      end
      if ((PTR_W+1)'(w_req_n) > r_count) begin
         w_pop_n = r_count[1:0];
      end else begin
         w_pop_n = w_req_n;
      end
   end

   // Write fetched entries into storage at wr_ptr and wr_ptr+1
   always_ff @(posedge clk) begin
      if (!flush && (w_push_n != 2'd0)) begin
         r_inst_mem[r_wr_ptr] <= fetch_inst1;
         r_addr_mem[r_wr_ptr] <= fetch_addr1;
         r_pkt_mem[r_wr_ptr]  <= fetch_pkt1;
         if (w_push_n == 2'd2) begin
            r_inst_mem[w_wr_ptr1] <= fetch_inst2;
            r_addr_mem[w_wr_ptr1] <= fetch_addr2;
            r_pkt_mem[w_wr_ptr1]  <= fetch_pkt2;
         end
      end
   end

   // Pointer, occupancy and delay-slot flag update; flush wins over push/pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_delayslot <= 1'b0;
      end else if (flush) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_delayslot <= 1'b0;
      end else begin
         r_count  <= r_count + (PTR_W+1)'(w_push_n) - (PTR_W+1)'(w_pop_n);
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
         if (w_pop_n != 2'd0) begin
            r_delayslot <= next_in_delayslot_i;
         end
      end
   end

   // Decode-facing outputs: head entries masked to NOP when not valid
   always_comb begin
      issue_en1         = (r_count != '0);
      issue_en2         = (r_count >= CNT_TWO);
      inst_o1           = 32'd0;
      inst_addr_o1      = 32'd0;
      predict_pkt_o     = '0;
      inst_o2           = 32'd0;
      inst_addr_o2      = 32'd0;
      is_in_delayslot_o = r_delayslot & issue_en1;
      if (issue_en1) begin
         inst_o1       = r_inst_mem[r_rd_ptr];
         inst_addr_o1  = r_addr_mem[r_rd_ptr];
         predict_pkt_o = r_pkt_mem[r_rd_ptr];
      end
      if (issue_en2) begin
         inst_o2      = r_inst_mem[w_rd_ptr1];
         inst_addr_o2 = r_addr_mem[w_rd_ptr1];
      end
   end

endmodule
